// File: rtl/bpu_if.sv
// bpu_if: fetch-side lookup and EX-side training signals of the branch predictor.
interface bpu_if;
    logic [31:0] if1_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [1:0]  upd_kind;

    modport master (
        output if1_pc, upd_en, upd_pc, upd_taken, upd_target, upd_kind,
        input  pred_taken, pred_target
    );

    modport slave (
        input  if1_pc, upd_en, upd_pc, upd_taken, upd_target, upd_kind,
        output pred_taken, pred_target
    );
endinterface

// File: rtl/bpu_btb_ras.sv
// bpu_btb_ras: tagged BTB with saturating counters and branch kinds, plus a resolve-time return address stack.
module bpu_btb_ras #(
    parameter int IDX_W     = 6,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 2,
    parameter int RAS_DEPTH = 4
) (
    input logic  clk,
    input logic  rst_n,
    bpu_if.slave bus
);
    localparam int N  = 1 << IDX_W;
    localparam int PW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0]    P_LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]    C_FULL = CW'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] C_WEAK = CNT_W'(1) << (CNT_W - 1);
    localparam logic [1:0]       K_COND = 2'b00;
    localparam logic [1:0]       K_CALL = 2'b10;
    localparam logic [1:0]       K_RET  = 2'b11;

    logic [N-1:0]     valid_q;
    logic [TAG_W-1:0] tag_q    [N];
    logic [31:0]      target_q [N];
    logic [CNT_W-1:0] cnt_q    [N];
    logic [1:0]       kind_q   [N];
    logic [31:0]      ras_q    [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;
    logic [CW-1:0]    ras_cnt;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, l_taken, u_hit;
    logic [PW-1:0]    ras_top;
    logic [CNT_W-1:0] u_cnt, u_cnt_nxt;

    assign l_idx   = bus.if1_pc[IDX_W+1:2];
    assign l_tag   = bus.if1_pc[IDX_W+2 +: TAG_W];
    assign u_idx   = bus.upd_pc[IDX_W+1:2];
    assign u_tag   = bus.upd_pc[IDX_W+2 +: TAG_W];
    assign ras_top = ras_ptr == '0 ? P_LAST : ras_ptr - 1'b1;

    // Reset clears valid_q asynchronously, so lookup falls back to pc+4 while rst_n is low.
    always_comb begin
        l_hit           = valid_q[l_idx] && tag_q[l_idx] == l_tag;
        l_taken         = l_hit && (kind_q[l_idx] != K_COND || cnt_q[l_idx][CNT_W-1]);
        bus.pred_taken  = l_taken;
        bus.pred_target = !l_taken ? bus.if1_pc + 32'd4 :
                          (kind_q[l_idx] == K_RET && ras_cnt != '0) ? ras_q[ras_top] : target_q[l_idx];
    end

    always_comb begin
        u_hit     = valid_q[u_idx] && tag_q[u_idx] == u_tag;
        u_cnt     = cnt_q[u_idx];
        u_cnt_nxt = bus.upd_taken ? (&u_cnt ? u_cnt : u_cnt + 1'b1) : (|u_cnt ? u_cnt - 1'b1 : u_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (bus.upd_en) begin
            if (!u_hit && bus.upd_taken)
                valid_q[u_idx] <= 1'b1;
            if (bus.upd_kind == K_CALL) begin
                ras_ptr <= ras_ptr == P_LAST ? '0 : ras_ptr + 1'b1;
                if (ras_cnt != C_FULL)
                    ras_cnt <= ras_cnt + 1'b1;
            end else if (bus.upd_kind == K_RET && ras_cnt != '0) begin
                ras_ptr <= ras_top;
                ras_cnt <= ras_cnt - 1'b1;
            end
        end
    end

    // Payload needs no reset: it is only observed through valid_q and ras_cnt.
    always_ff @(posedge clk) begin
        if (bus.upd_en) begin
            if (u_hit) begin
                cnt_q[u_idx]  <= u_cnt_nxt;
                kind_q[u_idx] <= bus.upd_kind;
                if (bus.upd_taken)
                    target_q[u_idx] <= bus.upd_target;
            end else if (bus.upd_taken) begin
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= bus.upd_target;
                kind_q[u_idx]   <= bus.upd_kind;
                cnt_q[u_idx]    <= C_WEAK;
            end
            if (bus.upd_kind == K_CALL)
                ras_q[ras_ptr] <= bus.upd_pc + 32'd4;
        end
    end
endmodule

// File: tb/tb_bpu_btb_ras.sv
// tb_bpu_btb_ras: directed and randomized checks of bpu_btb_ras against a queue/array reference model.
module tb_bpu_btb_ras;
    localparam int RD = 2;

    logic clk, rst_n;
    int   n_chk, n_fail;

    bpu_if bus ();

    bpu_btb_ras #(.IDX_W(6), .TAG_W(8), .CNT_W(2), .RAS_DEPTH(RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: BTB as plain arrays, RAS as a bounded queue (back = top).
    bit          m_valid [64];
    int          m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_cnt   [64];
    int          m_kind  [64];
    logic [31:0] m_ras   [$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_ras.delete();
    endtask

    task automatic m_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int i, t;
        i  = int'(pc[7:2]);
        t  = int'(pc[15:8]);
        tk = m_valid[i] && m_tag[i] == t && (m_kind[i] != 0 || m_cnt[i] >= 2);
        if (!tk) tg = pc + 32'd4;
        else if (m_kind[i] == 3 && m_ras.size() > 0) tg = m_ras[$];
        else tg = m_tgt[i];
    endtask

    task automatic m_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic [1:0] kd);
        int i, t;
        i = int'(pc[7:2]);
        t = int'(pc[15:8]);
        if (m_valid[i] && m_tag[i] == t) begin
            m_cnt[i]  = tk ? (m_cnt[i] < 3 ? m_cnt[i] + 1 : 3) : (m_cnt[i] > 0 ? m_cnt[i] - 1 : 0);
            m_kind[i] = int'(kd);
            if (tk) m_tgt[i] = tg;
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_tgt[i]   = tg;
            m_kind[i]  = int'(kd);
            m_cnt[i]   = 2;
        end
        if (kd == 2'b10) begin
            m_ras.push_back(pc + 32'd4);
            if (m_ras.size() > RD) void'(m_ras.pop_front());
        end else if (kd == 2'b11 && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
    endtask

    // One cycle: drive lookup + optional update, check lookup mid-cycle against the model, then clock.
    task automatic cyc(string tag, logic [31:0] pc, logic en, logic [31:0] upc, logic tk, logic [31:0] ut, logic [1:0] kd);
        logic        et;
        logic [31:0] etg;
        bus.if1_pc     = pc;
        bus.upd_en     = en;
        bus.upd_pc     = upc;
        bus.upd_taken  = tk;
        bus.upd_target = ut;
        bus.upd_kind   = kd;
        #4;
        m_pred(pc, et, etg);
        chk({tag, "_tk"}, 32'(bus.pred_taken), 32'(et));
        chk({tag, "_tgt"}, bus.pred_target, etg);
        @(posedge clk);
        if (en) m_upd(upc, tk, ut, kd);
        #1;
    endtask

    task automatic upd(logic [31:0] upc, logic tk, logic [31:0] ut, logic [1:0] kd);
        cyc("upd", 32'h0, 1'b1, upc, tk, ut, kd);
    endtask

    task automatic look(string tag, logic [31:0] pc, logic et, logic [31:0] etg);
        bus.if1_pc = pc;
        bus.upd_en = 1'b0;
        #4;
        chk({tag, "_tk"}, 32'(bus.pred_taken), 32'(et));
        chk({tag, "_tgt"}, bus.pred_target, etg);
        cyc(tag, pc, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
    endtask

    function automatic logic [31:0] rpc();
        return 32'h1c000000 | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 1) << 8);
    endfunction

    initial begin
        n_chk = 0;
        n_fail = 0;
        m_clear();
        rst_n          = 1'b0;
        bus.if1_pc     = 32'h1c000000;
        bus.upd_en     = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = '0;
        bus.upd_kind   = 2'b00;
        #2;
        chk("rst_tk", 32'(bus.pred_taken), 32'h0);
        chk("rst_tgt", bus.pred_target, 32'h1c000004);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        look("boot", 32'h1c000000, 1'b0, 32'h1c000004);
        upd(32'h1c000010, 1'b1, 32'h1c000040, 2'b00);
        look("alloc", 32'h1c000010, 1'b1, 32'h1c000040);
        upd(32'h1c000010, 1'b0, 32'h0, 2'b00);
        look("weak_nt", 32'h1c000010, 1'b0, 32'h1c000014);
        repeat (4) upd(32'h1c000010, 1'b1, 32'h1c000040, 2'b00);
        upd(32'h1c000010, 1'b0, 32'h0, 2'b00);
        look("sat", 32'h1c000010, 1'b1, 32'h1c000040);

        look("alias_miss", 32'h1c000110, 1'b0, 32'h1c000114);
        upd(32'h1c000110, 1'b1, 32'h1c000200, 2'b00);
        look("alias_hit", 32'h1c000110, 1'b1, 32'h1c000200);
        look("alias_evict", 32'h1c000010, 1'b0, 32'h1c000014);

        // Return entry trained first while the RAS is empty; calls are reported not-taken
        // so they do not evict it (0x100..0x400 all share index 0).
        upd(32'h400, 1'b1, 32'h9000, 2'b11);
        look("ret_empty", 32'h400, 1'b1, 32'h9000);
        upd(32'h100, 1'b0, 32'h0, 2'b10);
        upd(32'h200, 1'b0, 32'h0, 2'b10);
        upd(32'h300, 1'b0, 32'h0, 2'b10);
        look("ras_top", 32'h400, 1'b1, 32'h304);
        upd(32'h400, 1'b1, 32'h9000, 2'b11);
        look("ras_pop1", 32'h400, 1'b1, 32'h204);
        upd(32'h400, 1'b1, 32'h9000, 2'b11);
        upd(32'h400, 1'b1, 32'h9000, 2'b11);
        look("ras_empty", 32'h400, 1'b1, 32'h9000);

        for (int n = 0; n < 400; n++) begin
            logic [1:0] k;
            k = 2'($urandom_range(0, 3));
            cyc("rnd", rpc(), 1'($urandom_range(0, 3) != 0), rpc(), 1'($urandom), $urandom & 32'hfffffffc, k);
        end

        upd(32'h1c000010, 1'b1, 32'h1c000080, 2'b01);
        look("pre_rst", 32'h1c000010, 1'b1, 32'h1c000080);
        bus.if1_pc     = 32'h1c000010;
        bus.upd_en     = 1'b1;
        bus.upd_pc     = 32'h1c000020;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h1c000abc;
        bus.upd_kind   = 2'b00;
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_tk", 32'(bus.pred_taken), 32'h0);
        chk("mid_rst_tgt", bus.pred_target, 32'h1c000014);
        m_clear();
        @(posedge clk);
        #1 bus.upd_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        look("post_rst", 32'h1c000010, 1'b0, 32'h1c000014);
        look("post_rst_upd", 32'h1c000020, 1'b0, 32'h1c000024);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
